accum_sequencer: RTL

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/fft_pkg.sv | 22 ++
 rtl/accum_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT frame geometry, sequencer state encoding and helpers
package fft_pkg;

  localparam int FRAME_LEN = 128;
  localparam int ADDR_W    = 7;
  localparam int CNT_W     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ceil(log2(n)) for n >= 1; n == 1 yields 0
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - frame averaging sequencer: accumulate N FFT frames, then drain the sum
module accum_sequencer #(
  parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
  parameter int ADDR_W    = fft_pkg::ADDR_W,
  parameter int CNT_W     = fft_pkg::CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_continuous,
  input  logic [CNT_W-1:0]  i_num_avg,
  input  logic              i_data_valid,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_acc_clear,
  output logic              o_acc_en,
  output logic              o_fifo_wr_en,
  output logic              o_fifo_rd_en,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [CNT_W-1:0]  o_scale_shift,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic              o_busy,
  output logic              o_done
);
  import fft_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  shift_q, shift_d;
  logic              done_q, done_d;

  logic              in_beat;
  logic              rd_beat;
  logic              last_addr;
  logic              last_frame;
  logic              last_drain;
  logic [CNT_W-1:0]  n_in;

  // Abort masks every strobe in its own cycle, so nothing is half-written
  assign in_beat    = (state_q == ST_ACCUM) & i_data_valid & ~i_abort;
  assign rd_beat    = (state_q == ST_DRAIN) & i_out_ready & ~i_abort;
  assign last_addr  = (addr_q == ADDR_W'(FRAME_LEN - 1));
  assign last_frame = (frame_q == (n_q - CNT_W'(1)));
  assign last_drain = (drain_q == ADDR_W'(FRAME_LEN - 1));
  assign n_in       = (i_num_avg == '0) ? CNT_W'(1) : i_num_avg;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    frame_d = frame_q;
    n_d     = n_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      drain_d = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_ACCUM;
            addr_d  = '0;
            drain_d = '0;
            frame_d = '0;
            n_d     = n_in;
            shift_d = CNT_W'(ceil_log2(int'(n_in)));
          end
        end
        ST_ACCUM: begin
          if (in_beat) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_addr) begin
              if (last_frame) begin
                state_d = ST_DRAIN;
                frame_d = '0;
              end else begin
                frame_d = frame_q + CNT_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (rd_beat) begin
            drain_d = drain_q + ADDR_W'(1);
            if (last_drain) begin
              done_d  = 1'b1;
              drain_d = '0;
              if (i_continuous) begin
                // Back-to-back run: pick up a fresh N without passing through IDLE
                state_d = ST_ACCUM;
                addr_d  = '0;
                frame_d = '0;
                n_d     = n_in;
                shift_d = CNT_W'(ceil_log2(int'(n_in)));
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      frame_q <= '0;
      n_q     <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      frame_q <= frame_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign o_in_ready    = (state_q == ST_ACCUM) & ~i_abort;
  assign o_out_valid   = (state_q == ST_DRAIN) & ~i_abort;
  assign o_acc_en      = in_beat;
  assign o_acc_clear   = in_beat & (frame_q == '0);
  assign o_fifo_wr_en  = in_beat & last_frame;
  assign o_fifo_rd_en  = rd_beat;
  assign o_mem_addr    = addr_q;
  assign o_frame_cnt   = frame_q;
  assign o_scale_shift = shift_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;

endmodule
